// File: rtl/alu_result_serializer.sv
// Buffers 8-bit ALU results in a small FIFO and streams each one MSB-first on a
// cs_n/sclk/dout serial link. Optional even-parity bit: define ALU_SER_PARITY_EN.
module alu_result_serializer #(
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               res_data,
  input  logic                     res_valid,
  output logic                     res_ready,
  output logic                     ser_cs_n,
  output logic                     ser_sclk,
  output logic                     ser_dout,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef ALU_SER_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;

  // Handshake: a word transfers on a rising edge where res_valid and res_ready
  // are both high; res_ready depends only on the stored level.
  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  state_e           state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [DW-1:0]    divcnt_q, divcnt_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             dout_q, dout_d;
  logic             push, pop;
  logic [7:0]       head;

  assign res_ready  = (level_q != LW'(DEPTH));
  assign push       = res_valid & res_ready;
  assign head       = mem_q[rd_ptr_q];
  assign busy       = (state_q != ST_IDLE) | (level_q != '0);
  assign fifo_level = level_q;
  assign ser_cs_n   = cs_n_q;
  assign ser_sclk   = sclk_q;
  assign ser_dout   = dout_q;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    dout_d   = dout_q;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        // GAP may start the next frame directly so frames are spaced by one clk.
        if (level_q != '0) begin
          pop      = 1'b1;
`ifdef ALU_SER_PARITY_EN
          shreg_d  = {head, ^head};
`else
          shreg_d  = head;
`endif
          cs_n_d   = 1'b0;
          sclk_d   = 1'b0;
          dout_d   = head[7];
          bitcnt_d = '0;
          divcnt_d = '0;
          state_d  = ST_SHIFT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        divcnt_d = divcnt_q + DW'(1);
        if (divcnt_q == DW'(CLK_DIV - 1)) begin
          divcnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bitcnt_q == 4'(NBITS - 1)) begin
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            dout_d  = 1'b0;
            state_d = ST_GAP;
          end else begin
            sclk_d   = 1'b0;
            shreg_d  = shreg_q << 1;
            dout_d   = shreg_q[NBITS-2];
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      divcnt_q <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      dout_q   <= dout_d;
    end
  end

  // Storage needs no reset: the level counter decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= res_data;
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer: a serial-link monitor rebuilds each
// frame and the scenario tasks compare words, timing and FIFO level.
module tb_alu_result_serializer;

  localparam int DEPTH   = 4;
  localparam int CLK_DIV = 2;
`ifdef ALU_SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int FL = NB * 2 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic       ser_cs_n, ser_sclk, ser_dout, busy;
  logic [2:0] fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  logic [NB-1:0] exp_q[$];
  logic [NB-1:0] rx_q[$];
  int            len_q[$];
  int            gap_q[$];

  logic [NB-1:0] mon_sh;
  int            low_cnt, gap_cnt, max_level;
  bit            prev_cs, prev_sclk, seen_frame;

  alu_result_serializer #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .ser_cs_n(ser_cs_n), .ser_sclk(ser_sclk),
    .ser_dout(ser_dout), .busy(busy), .fifo_level(fifo_level)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NB-1:0] frame_of(input logic [7:0] d);
`ifdef ALU_SER_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  // serial receiver: samples dout on sclk rises, measures cs_n low/high spans
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cs = 1'b1; prev_sclk = 1'b0; mon_sh = '0;
      low_cnt = 0; gap_cnt = 0; seen_frame = 1'b0;
    end else begin
      if (!ser_cs_n) begin
        if (prev_cs) begin
          if (seen_frame) gap_q.push_back(gap_cnt);
          low_cnt = 0;
          mon_sh  = '0;
        end
        low_cnt++;
        if (ser_sclk && !prev_sclk) mon_sh = {mon_sh[NB-2:0], ser_dout};
      end else begin
        if (!prev_cs) begin
          rx_q.push_back(mon_sh);
          len_q.push_back(low_cnt);
          gap_cnt    = 0;
          seen_frame = 1'b1;
        end
        gap_cnt++;
      end
      prev_cs   = ser_cs_n;
      prev_sclk = ser_sclk;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end
  end

  // driver tasks
  task automatic clear_mon();
    exp_q.delete(); rx_q.delete(); len_q.delete(); gap_q.delete();
    seen_frame = 1'b0;
    max_level  = 0;
  endtask

  task automatic push_seq(input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input int n);
    logic [7:0] w[3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    for (int i = 0; i < n; i++) begin
      res_valid = 1'b1;
      res_data  = w[i];
      exp_q.push_back(frame_of(w[i]));
      @(negedge clk);
    end
    res_valid = 1'b0;
    res_data  = 'x;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset();
    int c;
    bit stayed;
    rst_n = 1'b0; res_valid = 1'b0; res_data = 'x;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ser_cs_n, ser_sclk, ser_dout, busy, fifo_level} !== {4'b1000, 3'd0}) begin
      n_err++;
      $display("FAIL reset_idle: cs/sclk/dout/busy/level = %b %b %b %b %0d, required 1 0 0 0 0",
               ser_cs_n, ser_sclk, ser_dout, busy, fifo_level);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (res_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: res_ready=%b required 1", res_ready);
    end
    clear_mon();
    push_seq(8'hAA, 8'hBB, 8'hCC, 3);
    c = 0;
    while (ser_cs_n !== 1'b0 && c < 20) begin @(negedge clk); c++; end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (ser_cs_n !== 1'b0 || fifo_level !== 3'd2) begin
      n_err++; $display("FAIL reset_preframe: cs_n=%b level=%0d required 0 and 2", ser_cs_n, fifo_level);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ser_cs_n, ser_sclk, ser_dout, busy, fifo_level} !== {4'b1000, 3'd0}) begin
      n_err++;
      $display("FAIL reset_midframe: cs/sclk/dout/busy/level = %b %b %b %b %0d, required 1 0 0 0 0",
               ser_cs_n, ser_sclk, ser_dout, busy, fifo_level);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    stayed = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (ser_cs_n !== 1'b1 || busy !== 1'b0) stayed = 1'b0;
    end
    n_cmp++;
    if (!stayed || rx_q.size() != 0) begin
      n_err++; $display("FAIL reset_no_resume: idle_held=%b frames=%0d required 1 and 0", stayed, rx_q.size());
    end
  endtask

  task automatic test_single_word();
    int c;
    bit ok;
    clear_mon();
    res_valid = 1'b1; res_data = 8'hA5;
    exp_q.push_back(frame_of(8'hA5));
    @(negedge clk);
    res_valid = 1'b0; res_data = 'x;
    n_cmp++;
    if (ser_cs_n !== 1'b1 || fifo_level !== 3'd1 || busy !== 1'b1) begin
      n_err++; $display("FAIL single_after_push: cs_n=%b level=%0d busy=%b required 1 1 1", ser_cs_n, fifo_level, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (ser_cs_n !== 1'b0 || fifo_level !== 3'd0 || ser_dout !== 1'b1 || ser_sclk !== 1'b0) begin
      n_err++; $display("FAIL single_start: cs_n=%b level=%0d dout=%b sclk=%b required 0 0 1 0",
                        ser_cs_n, fifo_level, ser_dout, ser_sclk);
    end
    c = 0;
    while (ser_cs_n !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    n_cmp++;
    if (ser_cs_n !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL single_gap: cs_n=%b busy=%b required 1 1", ser_cs_n, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || ser_cs_n !== 1'b1) begin
      n_err++; $display("FAIL single_idle: busy=%b cs_n=%b required 0 1", busy, ser_cs_n);
    end
    wait_rx(1, 5, ok);
    n_cmp++;
    if (!ok || rx_q[0] !== exp_q[0] || len_q[0] != FL) begin
      n_err++; $display("FAIL single_frame: frames=%0d word=%h len=%0d required 1 %h %0d",
                        rx_q.size(), ok ? rx_q[0] : '0, ok ? len_q[0] : 0, exp_q[0], FL);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_mon();
    push_seq(8'h01, 8'h80, 8'hFF, 3);
    res_valid = 1'b1; res_data = 8'h00;
    exp_q.push_back(frame_of(8'h00));
    @(negedge clk);
    res_valid = 1'b0; res_data = 'x;
    wait_rx(4, 4 * (FL + 2) + 20, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL b2b_timeout: frames=%0d required 4", rx_q.size());
    end
    n_cmp++;
    if (max_level != 3) begin
      n_err++; $display("FAIL b2b_peak_level: got %0d required 3", max_level);
    end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_q[i] || len_q[i] != FL) begin
        n_err++; $display("FAIL b2b_frame%0d: word=%h len=%0d required %h %0d", i, rx_q[i], len_q[i], exp_q[i], FL);
      end
    end
    n_cmp++;
    if (gap_q.size() != 3) begin
      n_err++; $display("FAIL b2b_gap_count: got %0d required 3", gap_q.size());
    end
    for (int i = 0; i < gap_q.size(); i++) begin
      n_cmp++;
      if (gap_q[i] != 1) begin
        n_err++; $display("FAIL b2b_gap%0d: got %0d clk required 1", i, gap_q[i]);
      end
    end
  endtask

  task automatic test_full();
    logic [7:0] w[6];
    int  idx, cyc;
    bit  saw_full, chk_after, ok;
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44; w[4] = 8'h55; w[5] = 8'h66;
    clear_mon();
    idx = 0; cyc = 0; saw_full = 1'b0; chk_after = 1'b0;
    while (idx < 6 && cyc < 400) begin
      res_valid = 1'b1;
      res_data  = w[idx];
      if (fifo_level == 3'd4) begin
        saw_full = 1'b1;
        n_cmp++;
        if (res_ready !== 1'b0) begin
          n_err++; $display("FAIL full_ready: res_ready=%b at level 4 required 0", res_ready);
        end
      end
      if (res_ready) begin
        if (saw_full && !chk_after) begin
          chk_after = 1'b1;
          n_cmp++;
          if (fifo_level !== 3'd3) begin
            n_err++; $display("FAIL full_resume_level: level=%0d required 3", fifo_level);
          end
        end
        exp_q.push_back(frame_of(w[idx]));
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    res_valid = 1'b0; res_data = 'x;
    n_cmp++;
    if (!saw_full || !chk_after || fifo_level !== 3'd4) begin
      n_err++; $display("FAIL full_refill: saw_full=%b resumed=%b level=%0d required 1 1 4",
                        saw_full, chk_after, fifo_level);
    end
    wait_rx(6, 6 * (FL + 2) + 20, ok);
    n_cmp++;
    if (rx_q.size() != 6) begin
      n_err++; $display("FAIL full_count: frames=%0d required 6", rx_q.size());
    end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL full_frame%0d: word=%h required %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_push_pop();
    int c;
    bit ok;
    clear_mon();
    push_seq(8'h3C, 8'hC3, 8'h5A, 3);
    c = 0;
    while (ser_cs_n !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    n_cmp++;
    if (ser_cs_n !== 1'b1 || fifo_level !== 3'd2) begin
      n_err++; $display("FAIL pushpop_pre: cs_n=%b level=%0d required 1 2", ser_cs_n, fifo_level);
    end
    res_valid = 1'b1; res_data = 8'h96;
    exp_q.push_back(frame_of(8'h96));
    @(negedge clk);
    res_valid = 1'b0; res_data = 'x;
    n_cmp++;
    if (fifo_level !== 3'd2 || ser_cs_n !== 1'b0) begin
      n_err++; $display("FAIL pushpop_level: level=%0d cs_n=%b required 2 0", fifo_level, ser_cs_n);
    end
    wait_rx(4, 4 * (FL + 2) + 20, ok);
    n_cmp++;
    if (rx_q.size() != 4) begin
      n_err++; $display("FAIL pushpop_count: frames=%0d required 4", rx_q.size());
    end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL pushpop_frame%0d: word=%h required %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef ALU_SER_PARITY_EN
  task automatic test_parity();
    logic [NB-1:0] want[2];
    bit ok;
    want[0] = 9'h00F;
    want[1] = 9'h006;
    clear_mon();
    push_seq(8'h07, 8'h03, 8'h00, 2);
    wait_rx(2, 2 * (FL + 2) + 20, ok);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (i >= rx_q.size() || rx_q[i] !== want[i] || len_q[i] != 36) begin
        n_err++; $display("FAIL parity_frame%0d: word=%h len=%0d required %h 36",
                          i, (i < rx_q.size()) ? rx_q[i] : '0, (i < len_q.size()) ? len_q[i] : 0, want[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_full();
    test_push_pop();
`ifdef ALU_SER_PARITY_EN
    test_parity();
`endif
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
